// File: rtl/csr_trap_seq.sv
// Sequencer in front of a single-port machine-mode CSR file. It turns csrrw/s/c(i),
// ecall and mret into ordered read/write cycles, stalls the core and issues trap redirects.
module csr_trap_seq #(
  parameter logic [31:0] MCAUSE_ECALL = 32'h0000_000B,
  parameter logic [11:0] ADDR_MSTATUS = 12'h300,
  parameter logic [11:0] ADDR_MTVEC   = 12'h305,
  parameter logic [11:0] ADDR_MEPC    = 12'h341,
  parameter logic [11:0] ADDR_MCAUSE  = 12'h342
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic        is_ecall,
  input  logic        is_mret,
  input  logic [2:0]  csr_op,
  input  logic [11:0] csr_addr_in,
  input  logic [4:0]  rs1_idx,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  rd_idx,
  input  logic [31:0] pc,
  input  logic [31:0] csr_rdata,
  output logic [11:0] csr_addr,
  output logic        csr_ren,
  output logic        csr_wen,
  output logic [31:0] csr_wdata,
  output logic        rd_wen,
  output logic [31:0] rd_wdata,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [3:0] {
    IDLE,
    E_MEPC,
    E_MCAUSE,
    E_MS_RD,
    E_MS_WR,
    E_VEC,
    M_MS_RD,
    M_MS_WR,
    M_EPC,
    C_RD,
    C_WR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] operand_q, operand_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] old_q, old_d;
  logic        no_write_q, no_write_d;

  logic        csr_op_valid;
  logic        accept;
  logic [31:0] ecall_mstatus;
  logic [31:0] mret_mstatus;
  logic [31:0] csr_result;

  assign csr_op_valid = (csr_op != 3'd0) && (csr_op != 3'd4);
  assign accept       = inst_valid && (is_ecall || is_mret || csr_op_valid);

  // op_q keeps only funct3[1:0]: register and immediate forms share the same update rule.
  always_comb begin
    ecall_mstatus        = old_q;
    ecall_mstatus[7]     = old_q[3];
    ecall_mstatus[3]     = 1'b0;
    ecall_mstatus[12:11] = 2'b11;

    mret_mstatus         = old_q;
    mret_mstatus[3]      = old_q[7];
    mret_mstatus[7]      = 1'b1;
    mret_mstatus[12:11]  = 2'b11;

    case (op_q)
      2'b10:   csr_result = old_q | operand_q;
      2'b11:   csr_result = old_q & ~operand_q;
      default: csr_result = operand_q;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    addr_d         = addr_q;
    operand_d      = operand_q;
    op_d           = op_q;
    rd_d           = rd_q;
    old_d          = old_q;
    no_write_d     = no_write_q;

    csr_addr       = 12'h000;
    csr_ren        = 1'b0;
    csr_wen        = 1'b0;
    csr_wdata      = 32'h0;
    rd_wen         = 1'b0;
    rd_wdata       = 32'h0;
    stall          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    case (state_q)
      IDLE: begin
        stall = accept;
        if (accept) begin
          pc_d       = pc;
          addr_d     = csr_addr_in;
          op_d       = csr_op[1:0];
          rd_d       = rd_idx;
          operand_d  = csr_op[2] ? {27'b0, rs1_idx} : rs1_data;
          no_write_d = csr_op[1] && (rs1_idx == 5'd0);
          if (is_ecall) begin
            state_d = E_MEPC;
          end else if (is_mret) begin
            state_d = M_MS_RD;
          end else begin
            state_d = C_RD;
          end
        end
      end

      E_MEPC: begin
        csr_wen   = 1'b1;
        csr_addr  = ADDR_MEPC;
        csr_wdata = pc_q & 32'hFFFF_FFFC;
        state_d   = E_MCAUSE;
      end

      E_MCAUSE: begin
        csr_wen   = 1'b1;
        csr_addr  = ADDR_MCAUSE;
        csr_wdata = MCAUSE_ECALL;
        state_d   = E_MS_RD;
      end

      E_MS_RD: begin
        csr_ren  = 1'b1;
        csr_addr = ADDR_MSTATUS;
        old_d    = csr_rdata;
        state_d  = E_MS_WR;
      end

      E_MS_WR: begin
        csr_wen   = 1'b1;
        csr_addr  = ADDR_MSTATUS;
        csr_wdata = ecall_mstatus;
        state_d   = E_VEC;
      end

      // Only direct-mode mtvec is supported, so the mode bits are simply masked off.
      E_VEC: begin
        csr_ren        = 1'b1;
        csr_addr       = ADDR_MTVEC;
        redirect_valid = 1'b1;
        redirect_pc    = {csr_rdata[31:2], 2'b00};
        state_d        = IDLE;
      end

      M_MS_RD: begin
        csr_ren  = 1'b1;
        csr_addr = ADDR_MSTATUS;
        old_d    = csr_rdata;
        state_d  = M_MS_WR;
      end

      M_MS_WR: begin
        csr_wen   = 1'b1;
        csr_addr  = ADDR_MSTATUS;
        csr_wdata = mret_mstatus;
        state_d   = M_EPC;
      end

      M_EPC: begin
        csr_ren        = 1'b1;
        csr_addr       = ADDR_MEPC;
        redirect_valid = 1'b1;
        redirect_pc    = {csr_rdata[31:2], 2'b00};
        state_d        = IDLE;
      end

      C_RD: begin
        csr_ren  = 1'b1;
        csr_addr = addr_q;
        old_d    = csr_rdata;
        state_d  = C_WR;
      end

      C_WR: begin
        csr_addr  = addr_q;
        csr_wen   = !no_write_q;
        csr_wdata = csr_result;
        rd_wen    = (rd_q != 5'd0);
        rd_wdata  = old_q;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= 32'h0;
      addr_q     <= 12'h000;
      operand_q  <= 32'h0;
      op_q       <= 2'b00;
      rd_q       <= 5'd0;
      old_q      <= 32'h0;
      no_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      operand_q  <= operand_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      old_q      <= old_d;
      no_write_q <= no_write_d;
    end
  end

endmodule

// File: doc/csr_trap_seq.md
Name: csr_trap_seq

Overview:
- Multi-cycle sequencer directly upstream of the machine-mode CSR file.
- Converts decoded csrrw/csrrs/csrrc/csrrwi/csrrsi/csrrci, ecall and mret into ordered single-port CSR read/write cycles.
- Updates mepc, mcause and mstatus; stalls the core while busy; issues a PC redirect on trap entry or return.
- Consumes the CSR file's combinational read data.

Parameters:
- MCAUSE_ECALL, 32'h0000000B, value written to mcause on ecall from M-mode.
- ADDR_MSTATUS, 12'h300, mstatus address.
- ADDR_MTVEC, 12'h305, mtvec address.
- ADDR_MEPC, 12'h341, mepc address.
- ADDR_MCAUSE, 12'h342, mcause address.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- inst_valid  in  1  decoded instruction present; sampled only in IDLE
- is_ecall  in  1  instruction is ecall
- is_mret  in  1  instruction is mret
- csr_op  in  3  funct3: 1 RW, 2 RS, 3 RC, 5 RWI, 6 RSI, 7 RCI; 0/4 = not a CSR op
- csr_addr_in  in  12  instruction CSR address
- rs1_idx  in  5  rs1 field, also the zimm source
- rs1_data  in  32  rs1 register value
- rd_idx  in  5  destination register index
- pc  in  32  PC of the instruction
- csr_rdata  in  32  combinational read data from the CSR file
- csr_addr  out  12  CSR file address
- csr_ren  out  1  CSR read enable
- csr_wen  out  1  CSR write enable
- csr_wdata  out  32  CSR write data
- rd_wen  out  1  GPR write enable, one cycle
- rd_wdata  out  32  GPR write data (old CSR value)
- stall  out  1  hold fetch/PC update
- redirect_valid  out  1  one-cycle PC redirect
- redirect_pc  out  32  redirect target

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- Reset: FSM goes to IDLE; latches (pc, addr, operand, op, rd, old value) clear to 0. The output values at reset are all 0.
- rst asserted mid-sequence aborts the sequence at the next edge. Partial CSR writes already performed stay in effect; no redirect is issued.

Accept (IDLE):
- Accept when inst_valid and (is_ecall | is_mret | csr_op ∉ {0,4}).
- Priority: ecall > mret > CSR op.
- At acceptance, latch pc, csr_addr_in, rd_idx and op.
- Latch the operand: rs1_data for ops 1–3; {27'b0, rs1_idx} for ops 5–7.
- Set the no-write flag for RS/RC/RSI/RCI when rs1_idx == 0.

stall:
- Combinational: stall = (state != IDLE) | (IDLE & accept).
- Deasserts in the cycle after the final state.

Outputs when not listed below:
- csr_ren, csr_wen, rd_wen and redirect_valid are 0.
- csr_addr, csr_wdata, rd_wdata and redirect_pc are 0.

ECALL (accepted at cycle T):
- T+1 E_MEPC: wen, addr ADDR_MEPC, wdata = latched pc with bits [1:0] forced 0.
- T+2 E_MCAUSE: wen, addr ADDR_MCAUSE, wdata = MCAUSE_ECALL.
- T+3 E_MS_RD: ren, addr ADDR_MSTATUS; capture csr_rdata.
- T+4 E_MS_WR: wen, addr ADDR_MSTATUS. wdata = captured value with MPIE[7] = old MIE[3], MIE[3] = 0, MPP[12:11] = 2'b11, all other bits unchanged.
- T+5 E_VEC: ren, addr ADDR_MTVEC; redirect_valid = 1, redirect_pc = {csr_rdata[31:2], 2'b00} (direct mode only).
- T+6: return to IDLE.

MRET (accepted at T):
- T+1 M_MS_RD: ren, addr ADDR_MSTATUS; capture.
- T+2 M_MS_WR: wen. wdata = captured value with MIE[3] = old MPIE[7], MPIE[7] = 1, MPP[12:11] = 2'b11 (M-only), others unchanged.
- T+3 M_EPC: ren, addr ADDR_MEPC; redirect_valid = 1, redirect_pc = {csr_rdata[31:2], 2'b00}.
- T+4: return to IDLE.

CSR op (accepted at T):
- T+1 C_RD: ren, addr = latched address; capture old value.
- T+2 C_WR: addr = latched address. Write data by op:
  - RW/RWI: operand.
  - RS/RSI: old | operand.
  - RC/RCI: old & ~operand.
- csr_wen = !no-write. rd_wen = (rd != 0); rd_wdata = old.
- RW with rd == 0 still performs the read cycle. No side effects exist; this is not a hazard.
- T+3: return to IDLE.

Other rules:
- Unsupported CSR address: the sequence runs unchanged; read data is whatever the CSR file returns (0); the CSR file drops the write.
- Inputs are ignored while not in IDLE. A new instruction may be accepted in the cycle that state returns to IDLE.
- All arithmetic is 32-bit bitwise; no carries.

Test Plan:
- rst high 2 cycles mid-ECALL (at E_MCAUSE) → next cycle IDLE, all outputs 0, no redirect, stall=0 when inst_valid=0.
- ECALL at pc=0x80000104, mtvec=0x80000400, mstatus=0x00001808 → mepc=0x80000104 (T+1), mcause=0xB (T+2), mstatus write 0x00001880 (T+4), redirect_pc=0x80000400 at T+5; stall high T..T+5.
- MRET with mstatus=0x00001880, mepc=0x80000108 → mstatus write 0x00001888 at T+2, redirect 0x80000108 at T+3, stall high T..T+3.
- CSRRS rd=5, rs1=x0, addr 0x300 (mstatus 0x1800) → csr_wen=0 at T+2, rd_wen=1, rd_wdata=0x1800.
- CSRRC rs1_data=0x0000000F on mtvec=0x8000040F → wdata 0x80000400. CSRRWI zimm=5 rd=0 → wdata 0x5, rd_wen=0.
- inst_valid with is_ecall=1 and is_mret=1 → ECALL sequence only. csr_op=4 with no ecall/mret → not accepted, stall=0.
